fifo_rd_stream: RTL and testbench

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

---
 rtl/fifo_rd_pkg.sv | 10 +
 rtl/skid_buf2.sv | 43 ++++
 rtl/fifo_rd_stream.sv | 65 ++++++
 tb/tb_fifo_rd_stream.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and default widths for the FIFO read streamer
package fifo_rd_pkg;
  localparam int unsigned C_WIDTH_DEF = 28;
  localparam int unsigned C_CNT_BITS_DEF = 16;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;
endpackage

// File: rtl/skid_buf2.sv
// skid_buf2: two-entry in-order buffer whose head entry is presented straight from flops
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int unsigned W = C_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);
  logic [1:0][W-1:0] mem_q, mem_d;
  logic head_q, head_d;
  logic [1:0] count_q, count_d;
  logic do_rd, do_wr;
  // reads need data, writes need a free slot (a same-edge read frees one); clr empties the buffer
  always_comb begin
    do_rd = rd & (count_q != 2'd0);
    do_wr = wr & ~clr & ((count_q != 2'd2) | do_rd);
    mem_d = mem_q;
    if (do_wr) mem_d[head_q ^ count_q[0]] = wdata;
    head_d = clr ? 1'b0 : head_q ^ do_rd;
    count_d = clr ? 2'd0 : count_q + {1'b0, do_wr} - {1'b0, do_rd};
  end
  // storage, head pointer and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
      head_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      head_q <= head_d;
      count_q <= count_d;
    end
  end
  assign rdata = mem_q[head_q];
  assign count = count_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: pops a first-word-fall-through FIFO into a skid-buffered valid/ready stream with flush
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned C_WIDTH = C_WIDTH_DEF,
  parameter int unsigned C_CNT_BITS = C_CNT_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [C_WIDTH-1:0]    fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic [C_WIDTH-1:0]    m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [C_CNT_BITS-1:0] fwd_count,
  output logic [C_CNT_BITS-1:0] drop_count
);
  state_t st_q, st_d;
  logic [C_CNT_BITS-1:0] fwd_q, fwd_d, drop_q, drop_d;
  logic [C_CNT_BITS:0] fwd_sum, drop_sum;
  logic [1:0] occ, drop_inc;
  logic xfer, wr;
  skid_buf2 #(.W(C_WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .wr    (wr),
    .wdata (fifo_dout),
    .rd    (xfer),
    .rdata (m_data),
    .count (occ)
  );
  assign m_valid = occ != 2'd0;
  assign xfer = m_valid & m_ready;
  assign busy = (st_q != ST_IDLE) | m_valid;
  // pop only on state and occupancy; a flush discards the skid and any word popped with it
  always_comb begin
    fifo_rd_en = ~rst & ~fifo_empty & ((st_q == ST_FLUSH) | ((st_q == ST_RUN) & ~occ[1]));
    wr = fifo_rd_en & (st_q == ST_RUN) & ~flush;
    drop_inc = flush ? occ - {1'b0, xfer} + {1'b0, fifo_rd_en} : {1'b0, fifo_rd_en & (st_q == ST_FLUSH)};
    fwd_sum = {1'b0, fwd_q} + (C_CNT_BITS + 1)'(xfer);
    drop_sum = {1'b0, drop_q} + (C_CNT_BITS + 1)'(drop_inc);
    fwd_d = fwd_sum[C_CNT_BITS] ? '1 : fwd_sum[C_CNT_BITS-1:0];
    drop_d = drop_sum[C_CNT_BITS] ? '1 : drop_sum[C_CNT_BITS-1:0];
    st_d = flush ? ST_FLUSH : (st_q == ST_FLUSH) ? (fifo_empty ? ST_IDLE : ST_FLUSH) : (enable ? ST_RUN : ST_IDLE);
  end
  // state and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= ST_IDLE;
      fwd_q <= '0;
      drop_q <= '0;
    end else begin
      st_q <= st_d;
      fwd_q <= fwd_d;
      drop_q <= drop_d;
    end
  end
  assign fwd_count = fwd_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for the FIFO read streamer
module tb_fifo_rd_stream;
  localparam int W = 28;
  localparam int CB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic flush = 1'b0;
  logic fifo_empty = 1'b1;
  logic m_ready = 1'b0;
  logic [W-1:0] fifo_dout = '0;
  logic fifo_rd_en, m_valid, busy;
  logic [W-1:0] m_data;
  logic [CB-1:0] fwd_count, drop_count;
  logic s_rd_en, s_valid, s_busy;
  logic [W-1:0] s_data;
  logic [1:0] s_fwd, s_drop;
  int tests = 0;
  int fails = 0;
  int pops = 0;
  logic pop_r = 1'b0;
  logic [W-1:0] fq[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;

  fifo_rd_stream #(.C_WIDTH(W), .C_CNT_BITS(CB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .fwd_count(fwd_count), .drop_count(drop_count)
  );

  // narrow-counter copy driven identically, used to observe saturation
  fifo_rd_stream #(.C_WIDTH(W), .C_CNT_BITS(2)) dut_sat (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .fifo_rd_en(s_rd_en), .m_data(s_data), .m_valid(s_valid),
    .m_ready(m_ready), .busy(s_busy), .fwd_count(s_fwd), .drop_count(s_drop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic upd();
    fifo_empty = (fq.size() == 0);
    fifo_dout = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // upstream FIFO model: pops what the DUT popped at the previous edge
  always begin
    @(posedge clk);
    #1;
    if (pop_r) begin
      void'(fq.pop_front());
      pops++;
      upd();
    end
  end

  // sample pop strobe and transfers mid-cycle; scoreboard the downstream stream
  always @(negedge clk) begin
    pop_r = fifo_rd_en;
    if (fifo_empty) begin
      tests++;
      if (fifo_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL rd_en_when_empty: fifo_rd_en=%b while fifo_empty=1", fifo_rd_en);
      end
    end
    if (m_valid && m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_extra: got %h, expected no transfer", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          fails++;
          $display("FAIL sb_data: got %h, expected %h", m_data, e);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic load(int n, logic [W-1:0] base, bit track);
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + W'(i));
      if (track) exp_q.push_back(base + W'(i));
    end
    upd();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    m_ready = 1'b0;
    fq.delete();
    exp_q.delete();
    upd();
    tick(2);
    rst = 1'b0;
  endtask

  task automatic wait_drain(string nm, int lim);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < lim) begin
      tick();
      i++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d words still expected, required 0", nm, exp_q.size());
    end
  endtask

  task automatic test_reset();
    tick(2);
    tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 || fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b data=%h busy=%b rd_en=%b, required 0", m_valid, m_data, busy, fifo_rd_en);
    end
    tests++;
    if (fwd_count !== '0 || drop_count !== '0) begin
      fails++;
      $display("FAIL reset_counters: fwd=%0d drop=%0d, required 0", fwd_count, drop_count);
    end
    rst = 1'b0;
    load(2, 'h50, 0);
    enable = 1'b1;
    tick();
    tests++;
    if (fifo_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL run_rd_en: fifo_rd_en=%b, required 1", fifo_rd_en);
    end
    rst = 1'b1;
    #1;
    tests++;
    if (fifo_rd_en !== 1'b0) begin
      fails++;
      $display("FAIL rd_en_in_reset: fifo_rd_en=%b, required 0", fifo_rd_en);
    end
    tick();
    tests++;
    if (pops !== 0 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_pop: pops=%0d valid=%b, required 0 0", pops, m_valid);
    end
    do_reset();
  endtask

  task automatic test_stream();
    int i;
    do_reset();
    m_ready = 1'b1;
    load(4, 'h1, 1);
    enable = 1'b1;
    i = 0;
    while (!m_valid && i < 10) begin
      tick();
      i++;
    end
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== W'(k)) begin
        fails++;
        $display("FAIL stream_word%0d: valid=%b data=%h, required 1 %h", k, m_valid, m_data, W'(k));
      end
      tick();
    end
    tests++;
    if (fwd_count !== 16'd4 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL stream_count: fwd=%0d valid=%b, required 4 0", fwd_count, m_valid);
    end
    enable = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    load(4, 'h1, 1);
    pops = 0;
    enable = 1'b1;
    tick(2);
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (m_valid !== 1'b1 || m_data !== W'(1)) begin
        fails++;
        $display("FAIL bp_hold%0d: valid=%b data=%h, required 1 0000001", k, m_valid, m_data);
      end
      tick();
    end
    tests++;
    if (pops !== 2 || fq.size() !== 2) begin
      fails++;
      $display("FAIL bp_pops: pops=%0d left=%0d, required 2 2", pops, fq.size());
    end
    m_ready = 1'b1;
    wait_drain("bp", 20);
    tests++;
    if (fwd_count !== 16'd4) begin
      fails++;
      $display("FAIL bp_count: fwd=%0d, required 4", fwd_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_flush();
    int i;
    do_reset();
    load(12, 'h100, 0);
    enable = 1'b1;
    tick(4);
    tests++;
    if (fq.size() !== 10 || m_valid !== 1'b1) begin
      fails++;
      $display("FAIL flush_pre: left=%0d valid=%b, required 10 1", fq.size(), m_valid);
    end
    flush = 1'b1;
    enable = 1'b0;
    tick();
    flush = 1'b0;
    tests++;
    if (m_valid !== 1'b0 || drop_count !== 16'd2) begin
      fails++;
      $display("FAIL flush_entry: valid=%b drop=%0d, required 0 2", m_valid, drop_count);
    end
    i = 0;
    while (busy && i < 40) begin
      tick();
      i++;
    end
    tests++;
    if (busy !== 1'b0 || fq.size() !== 0 || drop_count !== 16'd12 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL flush_done: busy=%b left=%0d drop=%0d valid=%b, required 0 0 12 0", busy, fq.size(), drop_count, m_valid);
    end
    tests++;
    if (s_drop !== 2'd3) begin
      fails++;
      $display("FAIL drop_saturate: drop=%0d, required 3", s_drop);
    end
  endtask

  task automatic test_enable_off();
    do_reset();
    m_ready = 1'b1;
    load(3, 'h200, 1);
    for (int k = 0; k < 20; k++) begin
      tests++;
      if (fifo_rd_en !== 1'b0) begin
        fails++;
        $display("FAIL disabled_rd_en%0d: fifo_rd_en=%b, required 0", k, fifo_rd_en);
      end
      tick();
    end
    tests++;
    if (fq.size() !== 3) begin
      fails++;
      $display("FAIL disabled_left: left=%0d, required 3", fq.size());
    end
    enable = 1'b1;
    wait_drain("enable", 20);
    tests++;
    if (fwd_count !== 16'd3) begin
      fails++;
      $display("FAIL enable_count: fwd=%0d, required 3", fwd_count);
    end
    enable = 1'b0;
  endtask

  task automatic test_saturation();
    do_reset();
    m_ready = 1'b1;
    load(6, 'h300, 1);
    enable = 1'b1;
    wait_drain("sat", 30);
    tests++;
    if (fwd_count !== 16'd6 || s_fwd !== 2'd3) begin
      fails++;
      $display("FAIL fwd_saturate: fwd=%0d narrow=%0d, required 6 3", fwd_count, s_fwd);
    end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic pv, pr;
    logic [W-1:0] pd;
    int i;
    do_reset();
    load(30, 'h1000, 1);
    enable = 1'b1;
    i = 0;
    while (exp_q.size() != 0 && i < 400) begin
      if (i == 15) load(10, 'h2000, 1);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      pv = m_valid;
      pr = m_ready;
      pd = m_data;
      tick();
      if (pv && !pr) begin
        tests++;
        if (m_valid !== 1'b1 || m_data !== pd) begin
          fails++;
          $display("FAIL b2b_hold: valid=%b data=%h, required 1 %h", m_valid, m_data, pd);
        end
      end
      i++;
    end
    tests++;
    if (exp_q.size() != 0 || fwd_count !== 16'd40) begin
      fails++;
      $display("FAIL b2b_count: pending=%0d fwd=%0d, required 0 40", exp_q.size(), fwd_count);
    end
    m_ready = 1'b0;
    enable = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    load(4, 'h400, 0);
    enable = 1'b1;
    tick(4);
    tests++;
    if (m_valid !== 1'b1 || fq.size() !== 2) begin
      fails++;
      $display("FAIL rstmid_pre: valid=%b left=%0d, required 1 2", m_valid, fq.size());
    end
    rst = 1'b1;
    tick();
    tests++;
    if (m_valid !== 1'b0 || m_data !== '0 || busy !== 1'b0 || fwd_count !== '0 || drop_count !== '0) begin
      fails++;
      $display("FAIL rstmid_state: valid=%b data=%h busy=%b fwd=%0d drop=%0d, required 0 0 0 0 0", m_valid, m_data, busy, fwd_count, drop_count);
    end
    enable = 1'b0;
    rst = 1'b0;
    fq.delete();
    upd();
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_enable_off();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    tick(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
